// File: rtl/div_unit_seq.sv
// -----------------------------------------------------------------------------
// div_unit_seq
//   Sequential signed divider for the multicycle CPU's DIV instruction.
//   It resolves one quotient bit per cycle using the restoring algorithm on
//   operand magnitudes, then applies the result signs in a final step.
//   LO receives the quotient and HI receives the remainder. The quotient
//   truncates toward zero, and the remainder takes the dividend's sign.
//   A zero divisor does not divide. It takes a short error path that pulses
//   done together with div_zero, and it leaves HI and LO untouched.
//
// Ports
//   clock     in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-high; clears all state
//   start     in   1      request, sampled only while idle
//   a_in      in   WIDTH  dividend (two's complement), sampled with start
//   b_in      in   WIDTH  divisor  (two's complement), sampled with start
//   hi_out    out  WIDTH  remainder register
//   lo_out    out  WIDTH  quotient register
//   busy      out  1      high while an operation is in progress
//   done      out  1      one-cycle pulse when the operation ends
//   div_zero  out  1      one-cycle pulse with done when the divisor was zero
// -----------------------------------------------------------------------------
module div_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, ERR} state_t;

  state_t state_reg, state_next;

  // dvd_reg starts as |dividend|. Quotient bits shift into it from the
  // bottom, so after WIDTH steps it holds the unsigned quotient.
  logic [WIDTH-1:0] dvd_reg;
  // The divisor and the partial remainder carry one extra bit. This lets
  // |-2^(W-1)| be represented exactly. It also keeps the shifted remainder
  // (which is always < 2*|divisor|) from overflowing.
  logic [WIDTH:0]   dvs_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CNT_W-1:0] count_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;

  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH:0]   a_mag, b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;

  // Operand magnitudes and one restoring step.
  always_comb begin
    a_ext     = {a_in[WIDTH-1], a_in};
    b_ext     = {b_in[WIDTH-1], b_in};
    a_mag     = a_in[WIDTH-1] ? -a_ext : a_ext;
    b_mag     = b_in[WIDTH-1] ? -b_ext : b_ext;
    rem_shift = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
    rem_diff  = rem_shift - dvs_reg;
    q_bit     = (rem_shift >= dvs_reg);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (b_in == '0) ? ERR : CALC;
        end
      end
      CALC: begin
        if (count_reg == LAST_STEP) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy drops on the same edge at which done rises. This lets a new
  // start be issued during the done cycle.
  assign busy = (state_reg != IDLE);

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      count_reg  <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      hi_out     <= '0;
      lo_out     <= '0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && (b_in != '0)) begin
            dvd_reg    <= a_mag[WIDTH-1:0];
            dvs_reg    <= b_mag;
            rem_reg    <= '0;
            count_reg  <= '0;
            sign_q_reg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            sign_r_reg <= a_in[WIDTH-1];
          end
        end
        CALC: begin
          rem_reg   <= q_bit ? rem_diff : rem_shift;
          dvd_reg   <= {dvd_reg[WIDTH-2:0], q_bit};
          count_reg <= count_reg + CNT_W'(1);
        end
        FIX: begin
          // Both result registers update together, here and nowhere else.
          // For the most negative value divided by -1, the quotient
          // magnitude is 2^(W-1). Its sign is positive, so it is written
          // unchanged and reads back as 0x80..0.
          lo_out <= sign_q_reg ? -dvd_reg : dvd_reg;
          hi_out <= sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
          done   <= 1'b1;
        end
        ERR: begin
          done     <= 1'b1;
          div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_div_unit_seq
//   Directed-vector bench for div_unit_seq (WIDTH = 32). Each scenario task
//   drives its own stimulus and compares results with hand-computed values.
//   Latency is counted in clock edges after the start-sampling edge. A
//   normal divide ends at edge 33, and a divide-by-zero ends at edge 1.
// -----------------------------------------------------------------------------
module tb_div_unit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int tests_run;
  int tests_failed;

  div_unit_seq #(.WIDTH(32)) dut (
    .clock    (clk),
    .reset    (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for done (bounded). The operands are
  // scrambled after the start edge, and this must have no effect. On return,
  // the bench sits 1 time unit into the done cycle, with the results captured.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic dz, output logic bsy, output int lat);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    lat   = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    lo  = lo_out;
    hi  = hi_out;
    dz  = div_zero;
    bsy = busy;
    $display("[TB] txn a=%h b=%h -> lo=%h hi=%h div_zero=%0b latency=%0d",
             a, b, lo, hi, dz, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, div_zero, hi_out, lo_out} !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h required all 0",
               busy, done, div_zero, hi_out, lo_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, hi_out, lo_out} !== 66'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b done=%b hi=%h lo=%h required all 0",
               busy, done, hi_out, lo_out);
    end
  endtask

  // T1: 7 / 2, plus a check on the width of the done pulse
  task automatic test_basic();
    logic [31:0] lo, hi;
    logic dz, bsy;
    int lat;
    run_div(32'd7, 32'd2, lo, hi, dz, bsy, lat);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL t1_latency: got %0d required 33", lat);
    end
    tests_run++;
    if ({lo, hi} !== {32'd3, 32'd1}) begin
      tests_failed++;
      $display("FAIL t1_result: got lo=%h hi=%h required lo=00000003 hi=00000001", lo, hi);
    end
    tests_run++;
    if ({bsy, dz} !== 2'b00) begin
      tests_failed++;
      $display("FAIL t1_flags: got busy=%b div_zero=%b required 0 0", bsy, dz);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_done_pulse: got done=%b one cycle later required 0", done);
    end
  endtask

  // T2 and other sign combinations
  task automatic test_signed();
    logic [31:0] lo, hi;
    logic dz, bsy;
    int lat;
    run_div(32'hFFFFFFF9, 32'd2, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin
      tests_failed++;
      $display("FAIL t2_neg_dividend: got lo=%h hi=%h required lo=fffffffd hi=ffffffff", lo, hi);
    end
    run_div(32'd7, 32'hFFFFFFFE, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi} !== {32'hFFFFFFFD, 32'd1}) begin
      tests_failed++;
      $display("FAIL t2_neg_divisor: got lo=%h hi=%h required lo=fffffffd hi=00000001", lo, hi);
    end
    run_div(32'hFFFFFFF9, 32'hFFFFFFFE, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi} !== {32'd3, 32'hFFFFFFFF}) begin
      tests_failed++;
      $display("FAIL t2_both_neg: got lo=%h hi=%h required lo=00000003 hi=ffffffff", lo, hi);
    end
  endtask

  // T3 and other extreme magnitudes
  task automatic test_overflow();
    logic [31:0] lo, hi;
    logic dz, bsy;
    int lat;
    run_div(32'h80000000, 32'hFFFFFFFF, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi, dz} !== {32'h80000000, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL t3_overflow: got lo=%h hi=%h dz=%b required lo=80000000 hi=00000000 dz=0",
               lo, hi, dz);
    end
    run_div(32'h80000000, 32'd2, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi} !== {32'hC0000000, 32'd0}) begin
      tests_failed++;
      $display("FAIL t3_min_by_2: got lo=%h hi=%h required lo=c0000000 hi=00000000", lo, hi);
    end
    run_div(32'h7FFFFFFF, 32'h80000000, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi} !== {32'd0, 32'h7FFFFFFF}) begin
      tests_failed++;
      $display("FAIL t3_max_by_min: got lo=%h hi=%h required lo=00000000 hi=7fffffff", lo, hi);
    end
  endtask

  // A zero dividend runs at full latency and clears previously held results.
  task automatic test_zero_dividend();
    logic [31:0] lo, hi;
    logic dz, bsy;
    int lat;
    run_div(32'd0, 32'd5, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi, lat} !== {32'd0, 32'd0, 32'd33}) begin
      tests_failed++;
      $display("FAIL zero_dividend: got lo=%h hi=%h lat=%0d required 0 0 33", lo, hi, lat);
    end
  endtask

  // T4: preload via 7/2, then divide by zero
  task automatic test_div_zero();
    logic [31:0] lo, hi;
    logic dz, bsy;
    int lat;
    run_div(32'd7, 32'd2, lo, hi, dz, bsy, lat);
    run_div(32'd5, 32'd0, lo, hi, dz, bsy, lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL t4_latency: got %0d required 1", lat);
    end
    tests_run++;
    if (dz !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_div_zero: got %b required 1", dz);
    end
    tests_run++;
    if ({lo, hi} !== {32'd3, 32'd1}) begin
      tests_failed++;
      $display("FAIL t4_retained: got lo=%h hi=%h required lo=00000003 hi=00000001", lo, hi);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({done, div_zero} !== 2'b00) begin
      tests_failed++;
      $display("FAIL t4_pulse: got done=%b dz=%b one cycle later required 0 0", done, div_zero);
    end
  endtask

  // T5: a start pulse while busy is ignored
  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'd100;
    b_in  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'd1;
        b_in  = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    $display("[TB] txn a=00000064 b=00000007 (restart ignored) -> lo=%h hi=%h latency=%0d",
             lo_out, hi_out, lat);
    tests_run++;
    if ({lo_out, hi_out, lat} !== {32'd14, 32'd2, 32'd33}) begin
      tests_failed++;
      $display("FAIL t5_ignored_start: got lo=%h hi=%h lat=%0d required 0000000e 00000002 33",
               lo_out, hi_out, lat);
    end
  endtask

  // T6: reset mid-operation, then a fresh divide
  task automatic test_reset_mid();
    logic [31:0] lo, hi;
    logic dz, bsy;
    int lat;
    logic saw_done;
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'd100;
    b_in  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, hi_out, lo_out} !== 66'd0) begin
      tests_failed++;
      $display("FAIL t6_async_reset: got busy=%b done=%b hi=%h lo=%h required all 0",
               busy, done, hi_out, lo_out);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL t6_no_done: got done pulse after reset required none");
    end
    run_div(32'd9, 32'd3, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi, lat} !== {32'd3, 32'd0, 32'd33}) begin
      tests_failed++;
      $display("FAIL t6_after_reset: got lo=%h hi=%h lat=%0d required 00000003 00000000 33",
               lo, hi, lat);
    end
  endtask

  // A start issued during the done cycle is accepted.
  task automatic test_back_to_back();
    logic [31:0] lo, hi;
    logic dz, bsy;
    int lat;
    run_div(32'd7, 32'd2, lo, hi, dz, bsy, lat);
    run_div(32'hFFFFFFEC, 32'd3, lo, hi, dz, bsy, lat);
    tests_run++;
    if ({lo, hi, lat} !== {32'hFFFFFFFA, 32'hFFFFFFFE, 32'd33}) begin
      tests_failed++;
      $display("FAIL b2b_result: got lo=%h hi=%h lat=%0d required fffffffa fffffffe 33",
               lo, hi, lat);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    rst   = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_zero_dividend();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
